// File: rtl/ser_nb_hdr.sv
// Serializer with per-frame header insertion and underflow tracking.
// Each frame is HDR_W header bits (HDR_VAL, MSB first) followed by WIDTH payload bits.
// Optional feature: define SER_PRBS_EN to make Mode 01 send a continuous PRBS7 payload;
// without it Mode 01 behaves exactly like Mode 00.
module ser_nb_hdr #(
  parameter int unsigned                          WIDTH    = 32,
  parameter int unsigned                          HDR_W    = 2,
  parameter logic [((HDR_W > 0) ? HDR_W : 1)-1:0] HDR_VAL  = 2'b01,
  parameter logic [WIDTH-1:0]                     IDLE_PAT = '0
) (
  input  logic             CLKBit,
  input  logic             RST,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             DataValid,
  output logic             DataReady,
  input  logic [1:0]       Mode,
  input  logic             MSBFirst,
  output logic             DataOut,
  output logic             CLKWord,
  output logic             Underflow,
  output logic [7:0]       UnderflowCnt
);

  localparam int unsigned    F       = HDR_W + WIDTH;
  localparam int unsigned    CntW    = $clog2(F);
  localparam logic [CntW-1:0] CntLast = CntW'(F - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(F / 2);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [F-1:0]     sr_q, frame_d;
  logic [WIDTH-1:0] payload, word, word_rev, clk_pat;
  logic             clkword_q, underflow_q;
  logic [7:0]       ufl_cnt_q;
  logic             load, data_mode, starve;

  assign load = (cnt_q == CntLast);
`ifdef SER_PRBS_EN
  assign data_mode = (Mode == 2'b00);
`else
  assign data_mode = (Mode[1] == 1'b0);
`endif
  assign starve       = load && data_mode && !DataValid;
  assign DataReady    = load && data_mode;
  assign DataOut      = sr_q[F-1];
  assign CLKWord      = clkword_q;
  assign Underflow    = underflow_q;
  assign UnderflowCnt = ufl_cnt_q;

  // Frame counter next state: wraps at the load cycle
  always_comb begin
    cnt_d = load ? '0 : cnt_q + 1'b1;
  end

  // Candidate payload words in transmit order (shift register sends its MSB first)
  always_comb begin
    word     = DataValid ? DataIn : IDLE_PAT;
    word_rev = '0;
    clk_pat  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      word_rev[i] = word[WIDTH-1-i];
      clk_pat[i]  = ((WIDTH - 1 - i) % 2 == 0);
    end
  end

`ifdef SER_PRBS_EN
  logic [6:0]       prbs_q, prbs_d;
  logic [WIDTH-1:0] prbs_bits;

  // Run the LFSR WIDTH steps ahead; bits land in generation order
  always_comb begin
    prbs_d    = prbs_q;
    prbs_bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      prbs_bits[WIDTH-1-i] = prbs_d[6] ^ prbs_d[5];
      prbs_d               = {prbs_d[5:0], prbs_d[6] ^ prbs_d[5]};
    end
  end

  // LFSR state only advances on frames actually sent in PRBS mode
  always_ff @(posedge CLKBit) begin
    if (RST) begin
      prbs_q <= 7'h7F;
    end else if (load && (Mode == 2'b01)) begin
      prbs_q <= prbs_d;
    end
  end
`endif

  // Payload selection; Mode and MSBFirst only matter in the load cycle
  always_comb begin
    payload = '0;
    unique case (Mode)
      2'b00:   payload = MSBFirst ? word : word_rev;
`ifdef SER_PRBS_EN
      2'b01:   payload = prbs_bits;
`else
      2'b01:   payload = MSBFirst ? word : word_rev;
`endif
      2'b10:   payload = clk_pat;
      2'b11:   payload = '0;
      default: payload = '0;
    endcase
  end

  if (HDR_W > 0) begin : g_hdr
    assign frame_d = {HDR_VAL, payload};
  end else begin : g_no_hdr
    assign frame_d = payload;
  end

  // Frame counter, shift register and registered status outputs
  always_ff @(posedge CLKBit) begin
    if (RST) begin
      cnt_q       <= CntLast;
      sr_q        <= '0;
      clkword_q   <= 1'b0;
      underflow_q <= 1'b0;
      ufl_cnt_q   <= 8'd0;
    end else begin
      cnt_q       <= cnt_d;
      sr_q        <= load ? frame_d : {sr_q[F-2:0], 1'b0};
      clkword_q   <= (cnt_d < CntHalf);
      underflow_q <= starve;
      if (starve && (ufl_cnt_q != 8'hFF)) begin
        ufl_cnt_q <= ufl_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ser_nb_hdr.sv
// Scoreboard bench for ser_nb_hdr (WIDTH=32, HDR_W=2, HDR_VAL=01, IDLE_PAT=0).
// A frame-level reference model predicts each cycle's outputs; a monitor checks them.
module tb_ser_nb_hdr;

  localparam int W = 32;
  localparam int F = 34;
`ifdef SER_PRBS_EN
  localparam bit PrbsEn = 1'b1;
`else
  localparam bit PrbsEn = 1'b0;
`endif

  logic        CLKBit, RST, DataValid, DataReady, MSBFirst, DataOut, CLKWord, Underflow;
  logic [31:0] DataIn;
  logic [1:0]  Mode;
  logic [7:0]  UnderflowCnt;

  ser_nb_hdr dut (
    .CLKBit       (CLKBit),
    .RST          (RST),
    .DataIn       (DataIn),
    .DataValid    (DataValid),
    .DataReady    (DataReady),
    .Mode         (Mode),
    .MSBFirst     (MSBFirst),
    .DataOut      (DataOut),
    .CLKWord      (CLKWord),
    .Underflow    (Underflow),
    .UnderflowCnt (UnderflowCnt)
  );

  initial begin
    CLKBit = 1'b0;
    forever #5 CLKBit = ~CLKBit;
  end

  typedef struct {
    bit       dout;
    bit       clkw;
    bit       rdy;
    bit       ufl;
    bit [7:0] ucnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   check_en = 1'b0;

  // Reference model state
  bit   frame[F];
  int   phase;
  bit   ufl_m;
  int   ucnt_m;
  bit   hist[$];

  task automatic model_reset();
    for (int i = 0; i < F; i++) frame[i] = 1'b0;
    phase  = F - 1;
    ufl_m  = 1'b0;
    ucnt_m = 0;
    hist.delete();
    for (int i = 0; i < 7; i++) hist.push_back(1'b1);
  endtask

  // PRBS7 recurrence b[n] = b[n-7] ^ b[n-6]
  function automatic bit prbs_next();
    bit b;
    b = hist[0] ^ hist[1];
    void'(hist.pop_front());
    hist.push_back(b);
    return b;
  endfunction

  task automatic load_frame(input bit valid, input logic [31:0] data, input logic [1:0] mode,
                            input bit msb, input bit dm);
    logic [31:0] w;
    frame[0] = 1'b0;
    frame[1] = 1'b1;
    w = valid ? data : 32'd0;
    for (int i = 0; i < W; i++) begin
      if (dm)                frame[2+i] = msb ? w[W-1-i] : w[i];
      else if (mode == 2'd1) frame[2+i] = prbs_next();
      else if (mode == 2'd2) frame[2+i] = (i % 2 == 0);
      else                   frame[2+i] = 1'b0;
    end
    phase = 0;
    ufl_m = dm && !valid;
    if (ufl_m && ucnt_m < 255) ucnt_m++;
  endtask

  // One clock cycle: drive inputs, queue the expected outputs, advance the model
  task automatic step(input bit rst, input bit valid, input logic [31:0] data,
                      input logic [1:0] mode, input bit msb);
    exp_t e;
    bit   dm;
    @(posedge CLKBit);
    #1;
    RST       = rst;
    DataValid = valid;
    DataIn    = data;
    Mode      = mode;
    MSBFirst  = msb;
    dm        = (mode == 2'd0) || (!PrbsEn && mode == 2'd1);
    e.dout    = frame[phase];
    e.clkw    = (phase < F / 2);
    e.rdy     = (phase == F - 1) && dm;
    e.ufl     = ufl_m;
    e.ucnt    = 8'(ucnt_m);
    if (check_en) exp_q.push_back(e);
    if (rst) begin
      model_reset();
    end else if (phase == F - 1) begin
      load_frame(valid, data, mode, msb, dm);
    end else begin
      phase++;
      ufl_m = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compares the DUT outputs away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge CLKBit);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("DataOut", {7'd0, DataOut}, {7'd0, e.dout});
        chk("CLKWord", {7'd0, CLKWord}, {7'd0, e.clkw});
        chk("DataReady", {7'd0, DataReady}, {7'd0, e.rdy});
        chk("Underflow", {7'd0, Underflow}, {7'd0, e.ufl});
        chk("UnderflowCnt", UnderflowCnt, e.ucnt);
      end
    end
  end

  initial begin
    RST = 1'b1; DataValid = 1'b0; DataIn = '0; Mode = 2'd0; MSBFirst = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 32'd0, 2'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 2'd0, 1'b1);
    check_en = 1'b1;
    // Known word MSB first, then LSB first
    repeat (2 * F) step(1'b0, 1'b1, 32'hA5A5_0F0F, 2'd0, 1'b1);
    repeat (F) step(1'b0, 1'b1, 32'hA5A5_0F0F, 2'd0, 1'b0);
    // Starvation: count climbs and saturates
    repeat (300 * F) step(1'b0, 1'b0, $urandom(), 2'd0, 1'($urandom_range(0, 1)));
    // Mid-frame switch to clock pattern
    while (phase != 10) step(1'b0, 1'b1, $urandom(), 2'd0, 1'b1);
    repeat (2 * F) step(1'b0, 1'b1, $urandom(), 2'd2, 1'($urandom_range(0, 1)));
    // PRBS / data-equivalent mode, then all-zero mode
    repeat (4 * F) step(1'b0, 1'b1, $urandom(), 2'd1, 1'($urandom_range(0, 1)));
    repeat (F) step(1'b0, 1'b1, $urandom(), 2'd3, 1'b1);
    // Reset pulse mid-frame
    while (phase != 20) step(1'b0, 1'b1, $urandom(), 2'd0, 1'b1);
    step(1'b1, 1'b1, $urandom(), 2'd0, 1'b1);
    repeat (2 * F) step(1'b0, 1'b1, $urandom(), 2'd0, 1'b1);
    // Fully random traffic with occasional resets
    repeat (30 * F) begin
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), $urandom(),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    repeat (2) @(posedge CLKBit);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
